// File: rtl/mux_sel_arbiter.sv
// Round-robin 4:1 mux select arbiter with registered one-hot grant.
// Optional burst limit: define MUX_SEL_ARBITER_BURST_LIMIT_EN.
module mux_sel_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last_idx;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       others;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST out of range 1..255");
  end

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  // First requester after last_idx, wrapping back to last_idx itself.
  always_comb begin
    win   = last_idx;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_idx + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign others = |(req & ~onehot(sel));

`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
  logic [7:0] burst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      gnt_valid <= 1'b0;
      last_idx  <= 2'd3;
      burst_cnt <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            gnt       <= onehot(win);
            sel       <= win;
            gnt_valid <= 1'b1;
            last_idx  <= win;
            burst_cnt <= 8'd0;
          end else begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            if (|req) begin
              gnt      <= onehot(win);
              sel      <= win;
              last_idx <= win;
            end else begin
              state     <= IDLE;
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
            end
            burst_cnt <= 8'd0;
          end else if (burst_cnt == 8'(MAX_BURST - 1)) begin
            // Owner still requesting: yield only if someone else waits.
            if (others) begin
              gnt      <= onehot(win);
              sel      <= win;
              last_idx <= win;
            end
            burst_cnt <= 8'd0;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      gnt_valid <= 1'b0;
      last_idx  <= 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            gnt       <= onehot(win);
            sel       <= win;
            gnt_valid <= 1'b1;
            last_idx  <= win;
          end else begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            if (|req) begin
              gnt      <= onehot(win);
              sel      <= win;
              last_idx <= win;
            end else begin
              state     <= IDLE;
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
            end
          end else if (others) begin
            // Owner keeps the mux until it drops its request.
            gnt <= onehot(sel);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
